// File: rtl/neural_pkg.sv
// Constants and state type shared by the result sequencer and the downstream
// seven-segment decode path.
package neural_pkg;

    localparam int          NUM_CLASSES = 10;
    localparam logic [15:0] THRESH      = 16'h0400;
    localparam int          CNT_W       = 4;
    localparam logic [3:0]  DIGIT_NONE  = 4'd10;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } seq_state_e;

endpackage

// File: rtl/neural_result_sequencer_if.sv
// Score stream in, digit result out. The network drives the master side and
// the sequencer sits on the slave side.
interface neural_result_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              score_valid;
    logic [DATA_W-1:0] score_data;
    logic              score_ready;
    logic [3:0]        digit;
    logic              digit_valid;
    logic              busy;

    modport master (
        output score_valid, score_data,
        input  score_ready, digit, digit_valid, busy
    );

    modport slave (
        input  score_valid, score_data,
        output score_ready, digit, digit_valid, busy
    );
endinterface

// File: rtl/neural_result_sequencer_argmax_scanner.sv
// Running argmax over one buffered frame. The threshold seeds best_val, so
// a class must strictly beat both THRESH and every earlier class to win.
module argmax_scanner #(
    parameter int              DATA_W = 16,
    parameter logic [DATA_W-1:0] THRESH = 16'h0400
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              init,
    input  logic              step,
    input  logic [3:0]        idx,
    input  logic [DATA_W-1:0] val,
    output logic [3:0]        best_idx
);
    import neural_pkg::*;

    logic [DATA_W-1:0] best_val_q, best_val_d;
    logic [3:0]        best_idx_q, best_idx_d;
    logic              cand_wins;

    // Strict compare keeps the lower index on ties.
    assign cand_wins = $signed(val) > $signed(best_val_q);

    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (init) begin
            best_val_d = THRESH;
            best_idx_d = DIGIT_NONE;
        end else if (step && cand_wins) begin
            best_val_d = val;
            best_idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            best_val_q <= THRESH;
            best_idx_q <= DIGIT_NONE;
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_idx = best_idx_q;

endmodule

// File: rtl/neural_result_sequencer.sv
// Buffers one frame of output-neuron scores, scans it for the thresholded
// argmax and publishes a held digit code with a one-cycle strobe.
module neural_result_sequencer #(
    parameter int                DATA_W      = 16,
    parameter int                NUM_CLASSES = neural_pkg::NUM_CLASSES,
    parameter logic [DATA_W-1:0] THRESH      = neural_pkg::THRESH
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    neural_result_sequencer_if.slave   seq_if
);
    import neural_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLASSES - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  scan_idx_q, scan_idx_d;
    logic [3:0]        digit_q, digit_d;
    logic [DATA_W-1:0] score_buf_q [NUM_CLASSES];
    logic [DATA_W-1:0] score_buf_d [NUM_CLASSES];

    logic       xfer;
    logic       buf_we;
    logic       scan_init;
    logic       scan_step;
    logic [3:0] best_idx;

    assign xfer = seq_if.score_valid && seq_if.score_ready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        scan_idx_d = scan_idx_q;
        digit_d    = digit_q;
        buf_we     = 1'b0;
        scan_init  = 1'b0;
        scan_step  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (xfer) begin
                    buf_we = 1'b1;
                    if (beat_cnt_q == LAST) begin
                        beat_cnt_d = '0;
                        scan_idx_d = '0;
                        scan_init  = 1'b1;
                        state_d    = SCAN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            SCAN: begin
                scan_step = 1'b1;
                if (scan_idx_q == LAST) begin
                    scan_idx_d = '0;
                    state_d    = DONE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            DONE: begin
                digit_d = best_idx;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        // Abort wins over everything, including a beat arriving this cycle.
        if (clear) begin
            state_d    = COLLECT;
            beat_cnt_d = '0;
            scan_idx_d = '0;
            digit_d    = digit_q;
            buf_we     = 1'b0;
            scan_init  = 1'b0;
            scan_step  = 1'b0;
        end
    end

    always_comb begin
        score_buf_d = score_buf_q;
        if (buf_we) score_buf_d[beat_cnt_q] = seq_if.score_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= COLLECT;
            beat_cnt_q <= '0;
            scan_idx_q <= '0;
            digit_q    <= DIGIT_NONE;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            scan_idx_q <= scan_idx_d;
            digit_q    <= digit_d;
        end
    end

    // Frame storage needs no reset; every entry is written before it is scanned.
    always_ff @(posedge clk) begin
        score_buf_q <= score_buf_d;
    end

    argmax_scanner #(
        .DATA_W (DATA_W),
        .THRESH (THRESH)
    ) u_scan (
        .clk      (clk),
        .n_rst    (n_rst),
        .init     (scan_init),
        .step     (scan_step),
        .idx      (scan_idx_q),
        .val      (score_buf_q[scan_idx_q]),
        .best_idx (best_idx)
    );

    assign seq_if.score_ready = (state_q == COLLECT);
    assign seq_if.busy        = (state_q != COLLECT);
    assign seq_if.digit_valid = (state_q == DONE) && !clear;
    assign seq_if.digit       = digit_q;

endmodule

// File: tb/tb_neural_result_sequencer.sv
// Directed frames with hand-computed winners, checking handshake timing,
// result latency, clear and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_neural_result_sequencer;
    import neural_pkg::*;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic clear = 1'b0;

    neural_result_sequencer_if #(.DATA_W(16)) sif ();

    neural_result_sequencer #(
        .DATA_W      (16),
        .NUM_CLASSES (10),
        .THRESH      (16'h0400)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (clear),
        .seq_if (sif)
    );

    always #5 clk = ~clk;

    int cnt_cmp = 0;
    int cnt_bad = 0;
    int xfers   = 0;
    logic [15:0] fr [10];

    always @(posedge clk)
        if (n_rst && !clear && sif.score_valid && sif.score_ready) xfers <= xfers + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        cnt_cmp++;
        if (act !== exp) begin
            cnt_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic set_frame(input logic [15:0] v);
        for (int i = 0; i < 10; i++) fr[i] = v;
    endtask

    // Present n beats of fr[]; returns after driving the last accepted beat.
    task automatic feed(input int n, input bit toggle);
        int  i     = 0;
        int  guard = 0;
        bit  ph    = 1'b0;
        while (i < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (toggle && ph) begin
                sif.score_valid = 1'b0;
            end else begin
                sif.score_valid = 1'b1;
                sif.score_data  = fr[i];
                if (sif.score_ready) i++;
            end
            ph = !ph;
        end
        if (i < n) chk("feed_timeout", i, n);
    endtask

    // The ten SCAN cycles; hold keeps score_valid high with junk data.
    task automatic scan_wait(input bit hold);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            sif.score_valid = hold;
            sif.score_data  = 16'h7FFF;
            chk("ready_scan", sif.score_ready, 1'b0);
            chk("dv_scan", sif.digit_valid, 1'b0);
            if (k == 1) chk("busy_scan", sif.busy, 1'b1);
        end
    endtask

    task automatic wait_result(input logic [3:0] exp, input bit hold, input int base);
        scan_wait(hold);
        @(negedge clk);
        chk("dv_done", sif.digit_valid, 1'b1);
        chk("ready_done", sif.score_ready, 1'b0);
        chk("busy_done", sif.busy, 1'b1);
        @(negedge clk);
        sif.score_valid = 1'b0;
        chk("digit", sif.digit, exp);
        chk("dv_after", sif.digit_valid, 1'b0);
        chk("ready_after", sif.score_ready, 1'b1);
        chk("busy_after", sif.busy, 1'b0);
        chk("xfers", xfers - base, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        sif.score_valid = 1'b0;
        sif.score_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_digit", sif.digit, 4'd10);
        chk("rst_dv", sif.digit_valid, 1'b0);
        chk("rst_ready", sif.score_ready, 1'b1);
        chk("rst_busy", sif.busy, 1'b0);
        n_rst = 1'b1;

        // Basic frame; valid held high through the scan must not be accepted.
        set_frame(16'h0000);
        fr[0] = 16'h0100; fr[1] = 16'h0500; fr[2] = 16'h0300; fr[3] = 16'h0800;
        base = xfers; feed(10, 1'b0); wait_result(4'd3, 1'b1, base);

        // All equal to threshold: nothing qualifies.
        set_frame(16'h0400);
        base = xfers; feed(10, 1'b0); wait_result(4'd10, 1'b0, base);

        // Tie goes to the lower index.
        set_frame(16'h0000);
        fr[2] = 16'h0900; fr[7] = 16'h0900;
        base = xfers; feed(10, 1'b0); wait_result(4'd2, 1'b0, base);

        // Signed compare: -1.0 must lose to just-above-threshold.
        set_frame(16'h0000);
        fr[0] = 16'hF000; fr[5] = 16'h0401;
        base = xfers; feed(10, 1'b0); wait_result(4'd5, 1'b0, base);

        // Gapped stream.
        set_frame(16'h0000);
        fr[8] = 16'h0600; fr[9] = 16'h0700;
        base = xfers; feed(10, 1'b1); wait_result(4'd9, 1'b0, base);

        // Partial frame aborted by clear, then a full fresh frame.
        set_frame(16'h0000);
        fr[1] = 16'h7000;
        feed(6, 1'b0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_ready", sif.score_ready, 1'b1);
        set_frame(16'h0000);
        fr[4] = 16'h0500;
        base = xfers; feed(10, 1'b0); wait_result(4'd4, 1'b0, base);

        // Clear during DONE: no strobe, digit keeps 4.
        set_frame(16'h0000);
        fr[8] = 16'h0600;
        feed(10, 1'b0);
        scan_wait(1'b0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clrdone_dv", sif.digit_valid, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        chk("clrdone_digit", sif.digit, 4'd4);
        chk("clrdone_busy", sif.busy, 1'b0);
        chk("clrdone_ready", sif.score_ready, 1'b1);

        // Asynchronous reset mid-scan, then a normal frame.
        set_frame(16'h0000);
        fr[0] = 16'h0401;
        feed(10, 1'b0);
        repeat (4) @(negedge clk);
        sif.score_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("arst_digit", sif.digit, 4'd10);
        chk("arst_busy", sif.busy, 1'b0);
        chk("arst_ready", sif.score_ready, 1'b1);
        chk("arst_dv", sif.digit_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        base = xfers; feed(10, 1'b0); wait_result(4'd0, 1'b0, base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end

endmodule

// File: doc/neural_result_sequencer.md
# neural_result_sequencer

Sequential classifier back-end between the neural network output layer and the seven-segment decode path. Accepts the ten output-neuron scores as a serial valid/ready stream, buffers one frame, and scans it one score per cycle for the winning class. It publishes a held 4-bit digit code (0–9, or 10 for "no confident class") with a one-cycle result strobe. It replaces first-above-threshold priority selection with true argmax-above-threshold, sequenced so the network can stream frames back to back.

## Interface
Parameters:
- DATA_W, 16, score width; Q4.12 signed two's complement.
- NUM_CLASSES, 10, scores per frame.
- THRESH, 16'h0400, minimum score (0.25 in Q4.12); a class qualifies only if its score is strictly greater than THRESH.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- n_rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort; discards any partial frame or scan.
- score_valid  in  1  network presents a score this cycle.
- score_data  in  DATA_W  score for class index = beat number within frame (beat 0 = class 0).
- score_ready  out  1  block accepts a score this cycle; a beat transfers when score_valid && score_ready.
- digit  out  4  winning class 0–9, or 10 when none qualifies; held between results.
- digit_valid  out  1  one-cycle pulse when digit updates.
- busy  out  1  high in SCAN and DONE.

## Operation
- States: COLLECT, SCAN, DONE.
- COLLECT: score_ready=1. Each transfer writes score_data to buf[beat_cnt] and increments beat_cnt. The transfer with beat_cnt==NUM_CLASSES-1 moves to SCAN, clears beat_cnt, sets scan_idx=0, best_idx=10, and best_val=THRESH.
- SCAN: score_ready=0. Each cycle compares buf[scan_idx] against best_val as signed values. If buf[scan_idx] is strictly greater, best_val and best_idx load from it. scan_idx then increments. After scan_idx==NUM_CLASSES-1 is evaluated, the state moves to DONE.
- Ties keep the lower index, because the comparison is strict.
- Scores equal to THRESH, or negative scores, never win. If no score qualifies, best_idx stays 10.
- DONE, one cycle: digit<=best_idx, digit_valid=1, score_ready=0, then return to COLLECT.
- digit holds its value until the next DONE; digit_valid is 0 in every other cycle.
- clear (any state): next state COLLECT, beat_cnt=0, scan_idx=0. If clear is asserted in DONE, the DONE-cycle update and pulse are suppressed and digit keeps its prior value. clear overrides a simultaneous score transfer; the beat is dropped.
- score_data contents are ignored when score_valid=0. score_valid asserted while score_ready=0 has no effect; the network must hold the beat.

## Timing
- Reset values: digit=4'd10, digit_valid=0, score_ready=1, busy=0, state=COLLECT, all counters 0. Buffer contents are don't-care.
- Reset mid-frame or mid-scan: immediate return to the reset values. No result is emitted.
- Latency: the final beat transfers at edge T. SCAN occupies cycles T+1..T+10. DONE is cycle T+11: digit_valid is high in that cycle, and digit shows the new value from edge T+11 onward.
- Throughput: one frame per NUM_CLASSES+NUM_CLASSES+1 = 21 cycles at full score_valid. score_ready reasserts in the cycle after DONE.
- beat_cnt and scan_idx are 4-bit and never exceed NUM_CLASSES-1. There is no wrap-around beyond the frame boundary.

## Structure
- Shared package neural_pkg holds: NUM_CLASSES, THRESH, DIGIT_NONE=4'd10, and the state enum typedef (COLLECT, SCAN, DONE). neural_to_seven and downstream display logic reuse the same constants.
- One sub-module, argmax_scanner: owns best_val/best_idx registers, the strict signed compare, and init/step/load controls. The top level owns the FSM, counters, buffer and handshake.

## Test plan
- Frame scores {0x0100,0x0500,0x0300,0x0800,0,0,0,0,0,0}, score_valid held high: score_ready low 11 cycles after last beat, digit_valid pulse at T+11, digit=3.
- Frame with all scores 0x0400 (equal to THRESH): digit=10. Frame with 0x0900 at classes 2 and 7: digit=2 (tie, lower index).
- Negative scores: class 0=0xF000 (−1.0), class 5=0x0401, others 0: digit=5. Confirms signed comparison.
- score_valid toggled 1/0 each cycle during COLLECT: exactly 10 transfers accepted. No transfer while score_ready=0 despite score_valid=1. Result matches the expected argmax.
- clear after 6 beats, then a full new frame: result reflects only the new frame. clear during DONE: no digit_valid, digit unchanged.
- Assert n_rst low during SCAN: digit=10, busy=0, score_ready=1 asynchronously. The next full frame produces a correct result with the normal latency.
